// File: rtl/lightboard_pkg.sv
// Shared definitions for the lightboard dibit link: receiver states, frame
// framing constants and the on-wire dibit ordering used by both link ends.
package lightboard_pkg;

  typedef enum logic [1:0] {
    RECV_ADDR  = 2'd0,
    RECV_PIXEL = 2'd1,
    RECV_AUDIO = 2'd2,
    WAIT_GAP   = 2'd3
  } rx_state_t;

  localparam int ADDR_BYTES      = 3;
  localparam int DIBITS_PER_BYTE = 4;

  // Dibit k of a byte carries bits [2k+1:2k]; dibit 0 goes on the wire first.
  function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] k);
    return b[{k, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/lightboard_row_receiver_assembler.sv
// Collects four dibits (first dibit = byte LSBs) into a byte and flags the
// cycle the fourth dibit arrives. Any invalid cycle or clear restarts the byte.
module dibit_byte_assembler
  import lightboard_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_valid,
  input  logic [1:0] i_dibit,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  logic [1:0] r_cnt;
  logic [5:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= 2'd0;
      r_shift <= 6'd0;
    end else if (i_clear || !i_valid) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_dibit, r_shift[5:2]};
    end
  end

  // Newest dibit lands on top, so after three shifts the oldest sits in [1:0].
  assign o_byte       = {i_dibit, r_shift};
  assign o_byte_valid = i_valid && !i_clear && (r_cnt == 2'(DIBITS_PER_BYTE - 1));

endmodule

// File: rtl/lightboard_row_receiver.sv
// Display-side receiver: rebuilds address/pixel/audio frames from the dibit
// link, writes pixels to the frame BRAM and strobes audio bytes out.
module lightboard_row_receiver
  import lightboard_pkg::*;
#(
  parameter int PIXELS_PER_ROW = 320,
  parameter int AUDIO_BYTES    = 8,
  parameter int ADDR_W         = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_axiiv,
  input  logic [1:0]        i_axiid,
  output logic              o_pix_we,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [7:0]        o_pix_data,
  output logic              o_audio_valid,
  output logic [7:0]        o_audio_data,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output rx_state_t         o_dbg_state
);

  localparam int MAX_CNT = (PIXELS_PER_ROW > AUDIO_BYTES) ? PIXELS_PER_ROW : AUDIO_BYTES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIXELS_PER_ROW - 1);
  localparam logic [CNT_W-1:0] LAST_AUD  = CNT_W'((AUDIO_BYTES > 0) ? AUDIO_BYTES - 1 : 0);
  localparam logic [1:0]       LAST_ABYT = 2'(ADDR_BYTES - 1);

  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [1:0]        r_abyte;
  logic [15:0]       r_addr;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_index;
  logic              r_started;
  logic              r_pix_we;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [7:0]        r_pix_data;
  logic              r_audio_valid;
  logic [7:0]        r_audio_data;
  logic              r_frame_done;
  logic              r_frame_err;

  logic [7:0]        w_byte;
  logic              w_byte_valid;
  logic              w_err;
  logic [23:0]       w_addr_full;

  dibit_byte_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (r_state == WAIT_GAP),
    .i_valid      (i_axiiv),
    .i_dibit      (i_axiid),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid)
  );

  // Address bytes arrive MSB first; only the low ADDR_W bits address the BRAM.
  assign w_addr_full = {r_addr, w_byte};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RECV_ADDR;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    case (r_state)
      RECV_ADDR: begin
        // r_started means a dibit was taken last cycle, so the frame had begun.
        if (!i_axiiv) w_err = r_started;
        else if (w_byte_valid && r_abyte == LAST_ABYT) w_state_next = RECV_PIXEL;
      end
      RECV_PIXEL: begin
        if (!i_axiiv) begin
          w_err        = 1'b1;
          w_state_next = RECV_ADDR;
        end else if (w_byte_valid && r_index == LAST_PIX) begin
          w_state_next = (AUDIO_BYTES == 0) ? WAIT_GAP : RECV_AUDIO;
        end
      end
      RECV_AUDIO: begin
        if (!i_axiiv) begin
          w_err        = 1'b1;
          w_state_next = RECV_ADDR;
        end else if (w_byte_valid && r_index == LAST_AUD) begin
          w_state_next = WAIT_GAP;
        end
      end
      WAIT_GAP: begin
        if (!i_axiiv) w_state_next = RECV_ADDR;
      end
      default: w_state_next = RECV_ADDR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_abyte       <= 2'd0;
      r_addr        <= 16'd0;
      r_base        <= '0;
      r_index       <= '0;
      r_started     <= 1'b0;
      r_pix_we      <= 1'b0;
      r_pix_addr    <= '0;
      r_pix_data    <= 8'd0;
      r_audio_valid <= 1'b0;
      r_audio_data  <= 8'd0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_pix_we      <= 1'b0;
      r_audio_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= w_err;
      r_started     <= i_axiiv;
      case (r_state)
        RECV_ADDR: begin
          if (!i_axiiv) begin
            r_abyte <= 2'd0;
          end else if (w_byte_valid) begin
            r_addr <= {r_addr[7:0], w_byte};
            if (r_abyte == LAST_ABYT) begin
              r_abyte <= 2'd0;
              r_base  <= ADDR_W'(w_addr_full);
              r_index <= '0;
            end else begin
              r_abyte <= r_abyte + 2'd1;
            end
          end
        end
        RECV_PIXEL: begin
          if (w_byte_valid) begin
            r_pix_we   <= 1'b1;
            r_pix_data <= w_byte;
            r_pix_addr <= r_base + ADDR_W'(r_index);
            if (r_index == LAST_PIX) begin
              r_index      <= '0;
              r_frame_done <= (AUDIO_BYTES == 0);
            end else begin
              r_index <= r_index + CNT_W'(1);
            end
          end
        end
        RECV_AUDIO: begin
          if (w_byte_valid) begin
            r_audio_valid <= 1'b1;
            r_audio_data  <= w_byte;
            if (r_index == LAST_AUD) begin
              r_index      <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_index <= r_index + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pix_we      = r_pix_we;
  assign o_pix_addr    = r_pix_addr;
  assign o_pix_data    = r_pix_data;
  assign o_audio_valid = r_audio_valid;
  assign o_audio_data  = r_audio_data;
  assign o_frame_done  = r_frame_done;
  assign o_frame_err   = r_frame_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lightboard_row_receiver.sv
// Bench for lightboard_row_receiver: frame table plus hand-written sequences
// for dibit order/latency, mid-frame reset and truncation corners.
module tb_lightboard_row_receiver;
  import lightboard_pkg::*;

  localparam int NPIX   = 320;
  localparam int NAUD   = 8;
  localparam int ADDR_W = 17;

  typedef struct {
    string       name;
    logic [23:0] addr;
    int          seed;
    int          trunc;       // dibits sent before axiiv drops; 0 = whole frame
    int          extra;       // bytes appended after the audio
    int          exp_writes;
    logic [16:0] exp_first;
    logic [16:0] exp_last;
    int          exp_audio;
    int          exp_done;
    int          exp_err;
  } row_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              axiiv;
  logic [1:0]        axiid;
  logic              o_pix_we;
  logic [ADDR_W-1:0] o_pix_addr;
  logic [7:0]        o_pix_data;
  logic              o_audio_valid;
  logic [7:0]        o_audio_data;
  logic              o_frame_done;
  logic              o_frame_err;
  rx_state_t         dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int cnt_pix, cnt_aud, cnt_done, cnt_err;
  logic [16:0] obs_first, obs_last;

  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0]        exp_aud_q[$];

  row_t rows[8];

  lightboard_row_receiver #(
    .PIXELS_PER_ROW (NPIX),
    .AUDIO_BYTES    (NAUD),
    .ADDR_W         (ADDR_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_axiiv       (axiiv),
    .i_axiid       (axiid),
    .o_pix_we      (o_pix_we),
    .o_pix_addr    (o_pix_addr),
    .o_pix_data    (o_pix_data),
    .o_audio_valid (o_audio_valid),
    .o_audio_data  (o_audio_data),
    .o_frame_done  (o_frame_done),
    .o_frame_err   (o_frame_err),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    cnt_pix = 0; cnt_aud = 0; cnt_done = 0; cnt_err = 0;
    obs_first = '0; obs_last = '0;
  endtask

  // Scoreboard: every strobe pops the expected queue; an empty queue gives a
  // zero flag bit, so a surplus strobe always miscompares.
  always @(negedge clk) begin
    logic [ADDR_W+8:0] exp_p;
    logic [8:0]        exp_a;
    if (o_pix_we) begin
      if (cnt_pix == 0) obs_first = o_pix_addr;
      obs_last = o_pix_addr;
      cnt_pix++;
      exp_p = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : '0;
      check("pix_write", 32'({o_pix_we, o_pix_addr, o_pix_data}), 32'(exp_p));
    end
    if (o_audio_valid) begin
      cnt_aud++;
      exp_a = (exp_aud_q.size() > 0) ? {1'b1, exp_aud_q.pop_front()} : '0;
      check("audio_byte", 32'({o_audio_valid, o_audio_data}), 32'(exp_a));
    end
    if (o_frame_done) begin
      cnt_done++;
      check("done_on_last_strobe",
            32'((o_pix_we | o_audio_valid) && exp_q.size() == 0 && exp_aud_q.size() == 0), 32'd1);
    end
    if (o_frame_err) cnt_err++;
  end

  // ---------------- drivers ----------------
  task automatic drive_dibit(input logic [1:0] d);
    axiid = d;
    axiiv = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2]);
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    axiid = 2'd0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] byte_at(input row_t r, input int idx);
    if (idx < 3)              return 8'(r.addr >> (8 * (2 - idx)));
    if (idx < 3 + NPIX)       return 8'(idx - 3 + r.seed);
    if (idx < 3 + NPIX + NAUD) return 8'(8'hA0 + idx - 3 - NPIX);
    return 8'(8'h5A ^ idx);
  endfunction

  task automatic check_outputs_idle(input string tag);
    check({tag, "_pix_we"},      32'(o_pix_we), 32'd0);
    check({tag, "_pix_addr"},    32'(o_pix_addr), 32'd0);
    check({tag, "_audio_valid"}, 32'(o_audio_valid), 32'd0);
    check({tag, "_frame_done"},  32'(o_frame_done), 32'd0);
    check({tag, "_frame_err"},   32'(o_frame_err), 32'd0);
    check({tag, "_state"},       32'(dbg_state), 32'(RECV_ADDR));
  endtask

  task automatic apply_row(input row_t r);
    int total, full, npix, naud;
    logic [7:0] b;
    clear_counts();
    total = 3 + NPIX + NAUD + r.extra;
    full  = (r.trunc > 0) ? r.trunc / 4 : total;
    npix  = (full - 3 < 0) ? 0 : ((full - 3 > NPIX) ? NPIX : full - 3);
    naud  = (full - 3 - NPIX < 0) ? 0 : ((full - 3 - NPIX > NAUD) ? NAUD : full - 3 - NPIX);
    for (int i = 0; i < npix; i++)
      exp_q.push_back({r.addr[16:0] + 17'(i), byte_at(r, i + 3)});
    for (int i = 0; i < naud; i++)
      exp_aud_q.push_back(byte_at(r, i + 3 + NPIX));
    for (int d = 0; d < total * 4; d++) begin
      if (r.trunc > 0 && d == r.trunc) break;
      b = byte_at(r, d / 4);
      drive_dibit(b[2 * (d % 4) +: 2]);
    end
    idle(4);
    check({r.name, "_writes"}, 32'(cnt_pix), 32'(r.exp_writes));
    if (r.exp_writes > 0) begin
      check({r.name, "_first_addr"}, 32'(obs_first), 32'(r.exp_first));
      check({r.name, "_last_addr"},  32'(obs_last),  32'(r.exp_last));
    end
    check({r.name, "_audio"},   32'(cnt_aud),  32'(r.exp_audio));
    check({r.name, "_done"},    32'(cnt_done), 32'(r.exp_done));
    check({r.name, "_err"},     32'(cnt_err),  32'(r.exp_err));
    check({r.name, "_leftover"}, 32'(exp_q.size() + exp_aud_q.size()), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    row_t post;
    rows[0] = '{"nominal",     24'h000140, 0, 0,                0, 320, 17'h00140, 17'h0027F, 8, 1, 0};
    rows[1] = '{"trunc_pix",   24'h000400, 3, (3 + 100) * 4 + 2, 0, 100, 17'h00400, 17'h00463, 0, 0, 1};
    rows[2] = '{"after_trunc", 24'h000000, 9, 0,                0, 320, 17'h00000, 17'h0013F, 8, 1, 0};
    rows[3] = '{"wrap",        24'h01FFF0, 1, 0,                0, 320, 17'h1FFF0, 17'h0012F, 8, 1, 0};
    rows[4] = '{"overlong",    24'hFE0010, 5, 0,                5, 320, 17'h00010, 17'h0014F, 8, 1, 0};
    rows[5] = '{"after_long",  24'h012345, 2, 0,                0, 320, 17'h12345, 17'h12484, 8, 1, 0};
    rows[6] = '{"trunc_addr",  24'h000777, 0, 5,                0, 0,   17'h00000, 17'h00000, 0, 0, 1};
    rows[7] = '{"trunc_audio", 24'h000800, 4, (3 + 320 + 3) * 4, 0, 320, 17'h00800, 17'h0093F, 3, 0, 1};

    rst = 1'b1; axiiv = 1'b0; axiid = 2'd0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_idle("reset");
    rst = 1'b0;
    idle(2);

    // Dibit order and one-cycle strobe latency: 0xB4 sent as 0,1,3,2.
    clear_counts();
    exp_q.push_back({17'h00020, 8'hB4});
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    drive_dibit(2'd0); drive_dibit(2'd1); drive_dibit(2'd3);
    axiid = 2'd2; axiiv = 1'b1;
    check("order_we_before", 32'(o_pix_we), 32'd0);
    @(posedge clk); #1;
    check("order_we_next_cycle", 32'(o_pix_we), 32'd1);
    check("order_data", 32'(o_pix_data), 32'hB4);
    check("order_addr", 32'(o_pix_addr), 32'h00020);
    axiiv = 1'b0;
    @(posedge clk); #1;
    check("order_we_one_cycle", 32'(o_pix_we), 32'd0);
    check("order_err_latency", 32'(o_frame_err), 32'd1);
    idle(3);
    check("order_err_count", 32'(cnt_err), 32'd1);
    check("order_writes", 32'(cnt_pix), 32'd1);

    for (int i = 0; i < 8; i++) apply_row(rows[i]);

    // Reset while pixel 50 is half received.
    clear_counts();
    for (int i = 0; i < 50; i++) exp_q.push_back({17'h00500 + 17'(i), 8'(i)});
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    for (int i = 0; i < 50; i++) send_byte(8'(i));
    drive_dibit(2'd2); drive_dibit(2'd1);
    rst = 1'b1; axiiv = 1'b0;
    @(posedge clk); #1;
    check_outputs_idle("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    check("midreset_writes", 32'(cnt_pix), 32'd50);
    check("midreset_err", 32'(cnt_err), 32'd0);
    check("midreset_done", 32'(cnt_done), 32'd0);

    post = '{"post_reset", 24'h000A00, 7, 0, 0, 320, 17'h00A00, 17'h00B3F, 8, 1, 0};
    apply_row(post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lightboard_row_receiver.md
Name: lightboard_row_receiver

Overview:
- Receive end of the 2-bit (dibit) lightboard link on the display-side FPGA.
- Reassembles each frame: a 3-byte row start address, PIXELS_PER_ROW pixel bytes, then AUDIO_BYTES audio bytes.
- Writes pixels into the frame BRAM with an incrementing address and streams audio bytes out.
- Sits between the link PHY/deserializer and the frame buffer and audio FIFO.

Parameters:
- PIXELS_PER_ROW, 320, pixel bytes per frame.
- AUDIO_BYTES, 8, audio bytes per frame after the pixels; 0 means no audio phase.
- ADDR_W, 17, width of the BRAM write address; lower ADDR_W bits of the 24-bit received address are used.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  dibit valid; high for the whole frame, low between frames.
- axiid  in  2  received dibit.
- pix_we  out  1  one-cycle BRAM write strobe.
- pix_addr  out  ADDR_W  BRAM write address.
- pix_data  out  8  BRAM write data.
- audio_valid  out  1  one-cycle audio byte strobe.
- audio_data  out  8  audio byte.
- frame_done  out  1  one-cycle pulse when a complete frame has been received.
- frame_err  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset: all outputs 0, state RECV_ADDR, dibit/byte counters 0, base address 0.

Wire format:
- Bytes are sent LSB dibit first: dibit k of a byte carries bits [2k+1:2k], k = 0..3.
- Address is 24 bits, sent MSB byte first (bits 23:16, then 15:8, then 7:0).
- A byte is complete on the cycle its 4th dibit is sampled with axiiv=1. Only cycles with axiiv=1 advance the counters.

States:
- RECV_ADDR: shift address bytes into a 24-bit register. After the 3rd byte, latch base = addr[ADDR_W-1:0], clear pixel index, go to RECV_PIXEL.
- RECV_PIXEL: on each completed byte, register one cycle later pix_we=1, pix_data=byte, pix_addr=(base+index) mod 2^ADDR_W, then index++.
  - After byte PIXELS_PER_ROW-1, go to RECV_AUDIO.
  - If AUDIO_BYTES=0, go directly to WAIT_GAP and pulse frame_done.
- RECV_AUDIO: on each completed byte, one cycle later audio_valid=1, audio_data=byte. After byte AUDIO_BYTES-1, pulse frame_done and go to WAIT_GAP.
- WAIT_GAP: ignore all input while axiiv=1; on axiiv=0 go to RECV_ADDR.

Latency and timing:
- Latency: 4th dibit sampled at cycle N → strobe at cycle N+1.
- frame_done asserts in the same cycle as the last data strobe.
- Back-to-back bytes give one strobe every 4 cycles minimum. No backpressure: the BRAM must accept every write.

Error handling:
- axiiv falling mid-frame (any state except WAIT_GAP, with ≥1 dibit already received this frame) → pulse frame_err next cycle.
  - Discard any partial byte and return to RECV_ADDR.
  - Pixels already written stay written.
- axiiv=0 in RECV_ADDR with zero dibits received is idle: no error.
- Excess bytes after frame end are dropped in WAIT_GAP.
- A new frame needs at least one axiiv=0 cycle after the previous one.

Reset mid-frame: same as power-on reset. No strobes fire on the reset cycle or the cycle after.

Address wrap: base+index wraps modulo 2^ADDR_W. Address bits above ADDR_W are ignored.

Decomposition:
- lightboard_pkg:
  - state enum rx_state_t {RECV_ADDR, RECV_PIXEL, RECV_AUDIO, WAIT_GAP}
  - ADDR_BYTES=3
  - DIBITS_PER_BYTE=4
  - the dibit-order definition, shared with the transmitter
- Sub-module dibit_byte_assembler:
  - inputs: axiiv/axiid and a clear signal
  - outputs: byte + byte_valid pulse, LSB-dibit-first assembly, 2-bit counter reset on clear or axiiv=0
  - reused by the transmitter-side loopback checker

Test Plan:
- Nominal frame: address 0x000140, 320 pixels of value i mod 256, 8 audio bytes 0xA0..0xA7 → 320 pix_we pulses, pix_addr 0x140..0x27F, pix_data matches, 8 audio_valid with 0xA0..0xA7, one frame_done on the last audio strobe.
- Dibit order: pixel byte 0xB4 sent as dibits 0,1,3,2 → pix_data=0xB4, pix_we exactly 1 cycle after the 4th dibit.
- Truncation: axiiv drops after 100 pixels plus 2 dibits → exactly 100 writes, one frame_err, no frame_done. The next full frame is received correctly.
- Wrap: address 0x01FFF0 with ADDR_W=17 → writes 0x1FFF0..0x1FFFF, then 0x00000 onward.
- Reset mid-pixel phase at pixel 50 → no further strobes. The following frame lands at its own address with index starting at 0.
- Overlong frame: 5 extra bytes after the audio with axiiv held high → ignored. After an axiiv gap, the next frame is accepted.
